// File: rtl/i2c_master.sv
// Single-master I2C bus initiator: START, control byte, nb_data write or read
// bytes with ACK/NACK handling, then STOP. Open-drain sclk/sda, byte handshake to the host.
module i2c_master #(
  parameter int G_CLK_DIV = 4,
  parameter int G_NB_DATA = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [6:0]                 chip_addr,
  input  logic                       rw,
  input  logic [$clog2(G_NB_DATA):0] nb_data,
  input  logic [7:0]                 wdata,
  output logic                       wdata_rd,
  output logic [7:0]                 rdata,
  output logic                       rdata_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       nack_error,
  inout  wire                        sclk,
  inout  wire                        sda
);

  localparam int NBW = $clog2(G_NB_DATA) + 1;
  localparam int QW  = $clog2(G_CLK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(G_CLK_DIV - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_CTRL  = 4'd2;
  localparam logic [3:0] S_SACK  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_WACK  = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_MACK  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  logic [3:0]     state;
  logic [QW-1:0]  q_cnt;
  logic [1:0]     phase;
  logic [2:0]     bit_cnt;
  logic [NBW-1:0] byte_cnt;
  logic [NBW-1:0] nb_lat;
  logic [6:0]     addr_lat;
  logic           rw_lat;
  logic [7:0]     sreg;
  logic           ack_bit;
  logic           scl_low;
  logic           sda_low;

  logic tick, sample, bit_end, more;

  assign tick    = (q_cnt == Q_LAST);
  assign sample  = tick && (phase == 2'd2);
  assign bit_end = tick && (phase == 2'd3);
  assign more    = (byte_cnt < nb_lat);

  // Line levels are a pure function of registered state, so they only move on clk edges.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state)
      S_START: begin
        sda_low = phase[1];
        scl_low = (phase == 2'd3);
      end
      S_CTRL, S_WDATA: begin
        scl_low = ~phase[1];
        sda_low = ~sreg[7];
      end
      S_SACK, S_WACK, S_RDATA: scl_low = ~phase[1];
      S_MACK: begin
        scl_low = ~phase[1];
        sda_low = more;
      end
      S_STOP: begin
        scl_low = ~phase[1];
        sda_low = (phase != 2'd3);
      end
      default: ;
    endcase
  end

  assign sclk = scl_low ? 1'b0 : 1'bz;
  assign sda  = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      q_cnt       <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      nb_lat      <= '0;
      addr_lat    <= '0;
      rw_lat      <= 1'b0;
      sreg        <= '0;
      ack_bit     <= 1'b0;
      wdata_rd    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nack_error  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      wdata_rd    <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;

      if (state == S_IDLE) begin
        q_cnt <= '0;
        phase <= '0;
        if (start) begin
          addr_lat   <= chip_addr;
          rw_lat     <= rw;
          nb_lat     <= nb_data;
          nack_error <= 1'b0;
          busy       <= 1'b1;
          bit_cnt    <= '0;
          byte_cnt   <= '0;
          state      <= S_START;
        end
      end else begin
        q_cnt <= tick ? '0 : q_cnt + 1'b1;
        if (tick) phase <= phase + 2'd1;

        if (sample) begin
          ack_bit <= sda;
          if (state == S_RDATA) sreg <= {sreg[6:0], sda};
        end

        if (bit_end) begin
          case (state)
            S_START: begin
              sreg  <= {addr_lat, rw_lat};
              state <= S_CTRL;
            end
            S_CTRL, S_WDATA: begin
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (state == S_WDATA) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  state    <= S_WACK;
                end else begin
                  state <= S_SACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                sreg    <= {sreg[6:0], 1'b0};
              end
            end
            S_SACK: begin
              if (ack_bit) begin
                nack_error <= 1'b1;
                state      <= S_STOP;
              end else if (nb_lat == '0) begin
                state <= S_STOP;
              end else if (!rw_lat) begin
                wdata_rd <= 1'b1;
                sreg     <= wdata;
                state    <= S_WDATA;
              end else begin
                state <= S_RDATA;
              end
            end
            S_WACK: begin
              if (ack_bit) begin
                nack_error <= 1'b1;
                state      <= S_STOP;
              end else if (more) begin
                wdata_rd <= 1'b1;
                sreg     <= wdata;
                state    <= S_WDATA;
              end else begin
                state <= S_STOP;
              end
            end
            S_RDATA: begin
              if (bit_cnt == 3'd7) begin
                bit_cnt     <= '0;
                byte_cnt    <= byte_cnt + 1'b1;
                rdata       <= sreg;
                rdata_valid <= 1'b1;
                state       <= S_MACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            S_MACK: state <= more ? S_RDATA : S_STOP;
            S_STOP: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural I2C slave on the open-drain bus, a
// transaction-level reference model, a vector table, random and hand-written cases.
module tb_i2c_master;

  localparam int CLK_DIV = 4;
  localparam int NB_MAX  = 256;
  localparam int NBW     = $clog2(NB_MAX) + 1;
  localparam logic [6:0] SLV_ADDR = 7'h50;
  localparam int NO_NACK = 1000;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    int         nb;
    int         nack_at;
    int         exp_nack;
    int         exp_str;
    int         dup_at;
  } vec_t;

  typedef struct packed {
    int nack;
    int xfer;
    int cycles;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [6:0]     chip_addr = '0;
  logic           rw = 1'b0;
  logic [NBW-1:0] nb_data = '0;
  logic [7:0]     wdata = '0;
  logic           wdata_rd, rdata_valid, busy, done, nack_error;
  logic [7:0]     rdata;
  wire            sclk, sda;
  logic           slv_low = 1'b0;

  pullup (sclk);
  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master #(.G_CLK_DIV(CLK_DIV), .G_NB_DATA(NB_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .chip_addr(chip_addr), .rw(rw),
    .nb_data(nb_data), .wdata(wdata), .wdata_rd(wdata_rd), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .nack_error(nack_error),
    .sclk(sclk), .sda(sda)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered by the monitor/slave process; the main test only reads them.
  int         cyc = 0, wrd_cnt = 0, done_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int         rise_t0 = 0, rise_t1 = 0;
  logic [7:0] ctrl_seen = '0;
  logic [7:0] wbuf[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_q[$];
  logic       mack_q[$];
  logic [7:0] slv_tx[8];
  logic [7:0] cur_wb[8];
  int         slv_nack_at = NO_NACK;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Transaction outcome from the protocol rules: bytes on the bus, error flag, duration.
  function automatic exp_t model(input logic [6:0] a, input logic r, input int nb, input int nack_at);
    exp_t e;
    if (a != SLV_ADDR) begin
      e.nack = 1; e.xfer = 0;
    end else if (!r && nack_at < nb) begin
      e.nack = 1; e.xfer = nack_at + 1;
    end else begin
      e.nack = 0; e.xfer = nb;
    end
    e.cycles = 4 * CLK_DIV * (2 + 9 * (1 + e.xfer));
    return e;
  endfunction

  // Slave at SLV_ADDR plus bus/handshake monitor, sampling once per clk.
  initial begin : monitor
    logic scl_c, sda_c, prev_scl, prev_sda, sel, srw, nacked;
    logic [7:0] ctrl, rx;
    int nrise, f, pos;
    prev_scl = 1'b1; prev_sda = 1'b1; sel = 1'b0; srw = 1'b0; nacked = 1'b0;
    ctrl = '0; rx = '0; nrise = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      scl_c = sclk;
      sda_c = sda;
      if (wdata_rd) wrd_cnt++;
      wdata = (wrd_cnt < wbuf.size()) ? wbuf[wrd_cnt] : 8'h00;
      if (rdata_valid) rd_q.push_back(rdata);
      if (done) done_cnt++;
      if (prev_scl && scl_c && prev_sda && !sda_c) begin
        start_cnt++;
        nrise = 0; sel = 1'b0; srw = 1'b0; nacked = 1'b0; slv_low = 1'b0;
      end else if (prev_scl && scl_c && !prev_sda && sda_c) begin
        stop_cnt++;
        nacked = 1'b1; slv_low = 1'b0;
      end else if (!prev_scl && scl_c) begin
        f = nrise / 9; pos = nrise % 9;
        if (nrise == 0) rise_t0 = cyc;
        if (nrise == 1) rise_t1 = cyc;
        if (f == 0 && pos < 8) begin
          ctrl = {ctrl[6:0], sda_c};
          if (pos == 7) begin
            ctrl_seen = ctrl;
            sel = (ctrl[7:1] == SLV_ADDR);
            srw = ctrl[0];
          end
        end else if (f > 0 && sel && !srw && pos < 8) begin
          rx = {rx[6:0], sda_c};
          if (pos == 7) rx_q.push_back(rx);
        end else if (f > 0 && sel && srw && pos == 8) begin
          mack_q.push_back(sda_c);
          if (sda_c) nacked = 1'b1;
        end
        nrise++;
      end else if (prev_scl && !scl_c) begin
        f = nrise / 9; pos = nrise % 9;
        slv_low = 1'b0;
        if (f == 0 && pos == 8) slv_low = sel;
        else if (f > 0 && sel && !srw && pos == 8) slv_low = ((f - 1) != slv_nack_at);
        else if (f > 0 && f <= 8 && sel && srw && pos < 8 && !nacked) slv_low = !slv_tx[f-1][7-pos];
      end
      prev_scl = scl_c;
      prev_sda = sda_c;
    end
  end

  task automatic load_wbuf(input int nb);
    while (wbuf.size() > wrd_cnt) void'(wbuf.pop_back());
    for (int i = 0; i < nb; i++) wbuf.push_back(cur_wb[i]);
  endtask

  task automatic run_txn(input string tag, input logic [6:0] a, input logic r, input int nb,
                         input int nack_at, input int exp_nack, input int exp_str, input int dup_at);
    exp_t e;
    int b_wrd, b_rd, b_rx, b_mk, b_done, b_start, b_stop, c, act;
    bit got;
    e = model(a, r, nb, nack_at);
    slv_nack_at = nack_at;
    load_wbuf(nb);
    @(posedge clk); #1;
    b_wrd = wrd_cnt; b_rd = rd_q.size(); b_rx = rx_q.size(); b_mk = mack_q.size();
    b_done = done_cnt; b_start = start_cnt; b_stop = stop_cnt;
    chip_addr = a; rw = r; nb_data = NBW'(nb); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_on_accept"}, int'(busy), 1);
    check({tag, " nack_cleared"}, int'(nack_error), 0);
    c = 0; got = 0;
    while (!got && c < e.cycles + 200) begin
      if (dup_at > 0 && c == dup_at) begin
        chip_addr = a ^ 7'h01; rw = ~r; nb_data = NBW'(nb + 3); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    check({tag, " done_latency"}, got ? c : -1, e.cycles);
    repeat (40) @(posedge clk);
    #1;
    check({tag, " nack_error"}, int'(nack_error), exp_nack);
    check({tag, " busy_after"}, int'(busy), 0);
    check({tag, " done_pulses"}, done_cnt - b_done, 1);
    check({tag, " start_cond"}, start_cnt - b_start, 1);
    check({tag, " stop_cond"}, stop_cnt - b_stop, 1);
    check({tag, " ctrl_byte"}, int'(ctrl_seen), int'({a, r}));
    check({tag, " scl_period"}, rise_t1 - rise_t0, 4 * CLK_DIV);
    check({tag, " wdata_rd_cnt"}, wrd_cnt - b_wrd, r ? 0 : exp_str);
    check({tag, " rdata_valid_cnt"}, rd_q.size() - b_rd, r ? exp_str : 0);
    for (int i = 0; i < e.xfer; i++) begin
      if (!r) begin
        act = (b_rx + i < rx_q.size()) ? int'(rx_q[b_rx + i]) : -1;
        check($sformatf("%s rx_byte%0d", tag, i), act, int'(cur_wb[i]));
      end else begin
        act = (b_rd + i < rd_q.size()) ? int'(rd_q[b_rd + i]) : -1;
        check($sformatf("%s rdata%0d", tag, i), act, int'(slv_tx[i]));
        act = (b_mk + i < mack_q.size()) ? int'(mack_q[b_mk + i]) : -1;
        check($sformatf("%s mack%0d", tag, i), act, (i == nb - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[10];
    exp_t e;
    logic [6:0] a;
    logic r;
    int nb, nk, b, b_done, c;

    vecs[0] = '{7'h50, 1'b0, 2, NO_NACK, 0, 2, 0};
    vecs[1] = '{7'h50, 1'b1, 3, NO_NACK, 0, 3, 0};
    vecs[2] = '{7'h51, 1'b0, 2, NO_NACK, 1, 0, 0};
    vecs[3] = '{7'h50, 1'b0, 0, NO_NACK, 0, 0, 0};
    vecs[4] = '{7'h50, 1'b0, 3, 1,       1, 2, 0};
    vecs[5] = '{7'h50, 1'b0, 1, 0,       1, 1, 0};
    vecs[6] = '{7'h50, 1'b1, 1, NO_NACK, 0, 1, 0};
    vecs[7] = '{7'h51, 1'b1, 2, NO_NACK, 1, 0, 0};
    vecs[8] = '{7'h50, 1'b0, 2, NO_NACK, 0, 2, 100};
    vecs[9] = '{7'h50, 1'b1, 2, NO_NACK, 0, 2, 300};

    cur_wb = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69};
    slv_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    repeat (3) @(posedge clk);
    #1;
    check("reset sclk_released", int'(sclk), 1);
    check("reset sda_released", int'(sda), 1);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset wdata_rd", int'(wdata_rd), 0);
    check("reset rdata_valid", int'(rdata_valid), 0);
    check("reset nack_error", int'(nack_error), 0);
    check("reset rdata", int'(rdata), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].nb,
              vecs[i].nack_at, vecs[i].exp_nack, vecs[i].exp_str, vecs[i].dup_at);

    for (int i = 0; i < 6; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLV_ADDR;
      r  = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 5);
      nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : NO_NACK;
      for (int j = 0; j < 8; j++) begin
        cur_wb[j] = 8'($urandom_range(0, 255));
        slv_tx[j] = 8'($urandom_range(0, 255));
      end
      e = model(a, r, nb, nk);
      run_txn($sformatf("rnd%0d", i), a, r, nb, nk, e.nack, e.xfer, 0);
    end

    // Reset during the first data byte of a write, then a clean transfer.
    cur_wb = '{8'hC6, 8'h39, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h42, 8'h24};
    slv_nack_at = NO_NACK;
    load_wbuf(2);
    @(posedge clk); #1;
    b = wrd_cnt;
    b_done = done_cnt;
    chip_addr = SLV_ADDR; rw = 1'b0; nb_data = NBW'(2); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (wrd_cnt == b && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort first_wdata_rd", wrd_cnt - b, 1);
    repeat (48) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort sclk_released", int'(sclk), 1);
    check("abort sda_released", int'(sda), 1);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("abort no_done", done_cnt - b_done, 0);
    check("abort still_idle", int'(busy), 0);
    run_txn("post_abort", SLV_ADDR, 1'b0, 2, NO_NACK, 0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Synchronous I2C bus-master verification block; the initiator counterpart of the team's I2C slave model.
- On a start request it generates START, sends the 7-bit address plus R/W bit, then performs nb_data write or read bytes with ACK/MACK handling, then generates STOP.
- Byte-level handshake toward the testbench; open-drain sclk/sda toward the DUT or slave model.
- Single master only: no arbitration, no clock stretching.

Parameters:
- G_CLK_DIV, 4, clk cycles per SCL quarter period (SCL period = 4*G_CLK_DIV clk); legal range ≥2.
- G_NB_DATA, 256, maximum bytes per transaction; sizes nb_data and the byte counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- start  in  1  one-clk request pulse; sampled only in IDLE
- chip_addr  in  7  slave address, latched on accepted start
- rw  in  1  0 = master write, 1 = master read; latched on accepted start
- nb_data  in  $clog2(G_NB_DATA)+1  data bytes after the control byte; latched on accepted start
- wdata  in  8  next write byte; must be valid whenever wdata_rd pulses
- wdata_rd  out  1  one-clk pulse: wdata captured into the shift register
- rdata  out  8  last received byte
- rdata_valid  out  1  one-clk pulse: rdata updated
- busy  out  1  high from accepted start until STOP completes
- done  out  1  one-clk pulse when STOP completes
- nack_error  out  1  sticky; set on slave NACK, cleared on the next accepted start
- sclk  inout  1  open drain: drives 0 or Z
- sda  inout  1  open drain: drives 0 or Z

Behaviour:
- Reset: sclk and sda released (Z), FSM in IDLE, all counters 0; wdata_rd, rdata_valid, busy, done, nack_error all 0; rdata = 0x00.
- Reset mid-transfer: both lines released on the next clk edge and FSM returns to IDLE; no STOP is generated.
- Timing:
  - quarter counter counts 0..G_CLK_DIV-1; phase counter counts 0..3.
  - Each bit is 4 quarters: Q0 SCL low, SDA updated; Q1 SCL low; Q2 SCL released; Q3 SCL released.
  - sda is sampled on the last clk of Q2.
- FSM states:
  - IDLE: lines released. On start: latch chip_addr, rw, nb_data; clear nack_error; set busy; go to START.
  - START: Q0-Q1 SDA and SCL released; Q2 SDA low; Q3 SCL low. Then go to CTRL with shift register = {chip_addr, rw}.
  - CTRL: send 8 bits, MSB first, then go to SACK.
  - SACK: SDA released for one bit and sampled.
    - Sample 1: set nack_error, go to STOP.
    - Sample 0 and nb_data = 0: go to STOP.
    - Sample 0, rw = 0: pulse wdata_rd (load wdata), go to WDATA.
    - Sample 0, rw = 1: go to RDATA.
  - WDATA: send 8 bits, then go to WACK (sampled like SACK).
    - NACK: set nack_error, go to STOP.
    - ACK with bytes remaining: pulse wdata_rd, go to WDATA.
    - ACK on the last byte: go to STOP.
  - RDATA: SDA released; shift in 8 samples, MSB first. After the 8th bit, update rdata and pulse rdata_valid in the same clk; go to MACK.
  - MACK: drive SDA 0 if bytes remain, otherwise release it (NACK on the last byte). Then go to RDATA or STOP.
  - STOP: Q0 SCL low, SDA low; Q1 hold; Q2 SCL released; Q3 SDA released. Then pulse done, clear busy, go to IDLE.
- Byte counter counts data bytes only, compared against the latched nb_data. Changing nb_data while busy has no effect.
- start while busy is ignored; it is not queued.
- An SDA low sample on the last byte's WACK behaves as ACK. A NACK on any write byte aborts the transfer.
- wdata_rd is asserted exactly nb_data times per successful write. rdata_valid is asserted exactly nb_data times per successful read.

Test Plan:
- Write: G_CLK_DIV = 4, slave addr 0x50, chip_addr = 0x50, rw = 0, nb_data = 2, wdata 0xA5 then 0x3C -> control byte 0xA0 on bus; slave RX memory holds 0xA5, 0x3C; wdata_rd pulses twice; SCL period 16 clk; done pulses once; nack_error = 0.
- Read: slave TX memory preloaded 0x11, 0x22, 0x33; rw = 1; nb_data = 3 -> rdata_valid pulses with 0x11, 0x22, 0x33; MACK low on bytes 1-2 and high on byte 3; STOP generated.
- Bad address: chip_addr = 0x51 against slave 0x50 -> SDA high at SACK; nack_error = 1; STOP follows immediately; wdata_rd never pulses; done = 1.
- Address only: nb_data = 0, rw = 0 -> START, control byte, ACK, STOP; zero wdata_rd pulses.
- Start while busy: second start pulse mid-byte -> ignored; exactly one done pulse; a subsequent start after done is accepted and clears nack_error.
- Reset mid-transfer: rst asserted during byte 1 of a write -> next clk sclk = Z, sda = Z, busy = 0, done = 0; a new transfer then completes normally.
